// File: rtl/hwpe_ctrl_ctx_sched.sv
// Job-context scheduler for an HWPE controller: a ring of job contexts that
// cores acquire and trigger, and a small engine FSM that launches them in order.
module hwpe_ctrl_ctx_sched #(
    parameter int unsigned N_CONTEXT = 4,
    parameter int unsigned N_CORES   = 16,
    parameter int unsigned ID_WIDTH  = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           softclear_i,

    input  logic                           acquire_i,
    input  logic [$clog2(N_CORES)-1:0]     acquire_core_i,
    output logic                           acquire_ok_o,
    output logic [ID_WIDTH-1:0]            acquire_id_o,

    input  logic                           trigger_i,
    output logic                           start_o,
    output logic [$clog2(N_CONTEXT)-1:0]   running_ctx_o,
    output logic [$clog2(N_CONTEXT)-1:0]   pointer_ctx_o,

    input  logic                           done_i,
    output logic [N_CORES-1:0]             evt_o,
    output logic                           busy_o,
    output logic [$clog2(N_CONTEXT):0]     queued_o,
    output logic [15:0]                    finished_o,
    output logic                           err_o
);

    localparam int unsigned CTX_W  = $clog2(N_CONTEXT);
    localparam int unsigned CORE_W = $clog2(N_CORES);
    localparam int unsigned CNT_W  = CTX_W + 1;
    localparam int unsigned FIN_W  = 16;

    typedef enum logic [1:0] {
        CTX_FREE,
        CTX_ACQUIRED,
        CTX_QUEUED,
        CTX_RUNNING
    } ctx_state_e;

    typedef enum logic [1:0] {
        ENG_IDLE,
        ENG_START,
        ENG_BUSY
    } eng_state_e;

    ctx_state_e            ctx_state_q [N_CONTEXT];
    logic [CORE_W-1:0]     ctx_owner_q [N_CONTEXT];

    logic [CTX_W-1:0]      ptr_q;
    logic [CTX_W-1:0]      run_q;
    logic [CTX_W-1:0]      acq_ctx_q;
    logic                  lock_q;
    logic [ID_WIDTH-1:0]   job_cnt_q;
    logic [CNT_W-1:0]      queued_q;
    logic [FIN_W-1:0]      finished_q;
    logic [N_CORES-1:0]    evt_q;
    logic                  err_q;
    eng_state_e            eng_q;

    logic clear;
    logic acq_grant;
    logic trig_ok;
    logic trig_err;
    logic done_ok;
    logic done_err;
    logic eng_launch;

    // Event qualification, all decided on pre-edge state
    assign clear      = rst_i | softclear_i;
    assign acq_grant  = acquire_i & ~clear & ~lock_q & (ctx_state_q[ptr_q] == CTX_FREE);
    assign trig_ok    = trigger_i & lock_q;
    assign trig_err   = trigger_i & ~lock_q;
    assign done_ok    = done_i & (eng_q == ENG_BUSY);
    assign done_err   = done_i & (eng_q != ENG_BUSY);
    assign eng_launch = (eng_q == ENG_IDLE) & (queued_q != '0);

    assign acquire_ok_o  = acq_grant;
    assign acquire_id_o  = acq_grant ? job_cnt_q : '1;

    assign start_o       = (eng_q == ENG_START);
    assign busy_o        = (eng_q != ENG_IDLE);
    assign running_ctx_o = run_q;
    assign pointer_ctx_o = ptr_q;
    assign evt_o         = evt_q;
    assign queued_o      = queued_q;
    assign finished_o    = finished_q;
    assign err_o         = err_q;

    // Per-context state; the four events always target contexts in distinct states
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < N_CONTEXT; i++) begin
            if (clear) begin
                ctx_state_q[i] <= CTX_FREE;
                ctx_owner_q[i] <= '0;
            end else begin
                if (acq_grant && (CTX_W'(i) == ptr_q)) begin
                    ctx_state_q[i] <= CTX_ACQUIRED;
                    ctx_owner_q[i] <= acquire_core_i;
                end
                if (trig_ok && (CTX_W'(i) == acq_ctx_q)) begin
                    ctx_state_q[i] <= CTX_QUEUED;
                end
                if (eng_launch && (CTX_W'(i) == run_q)) begin
                    ctx_state_q[i] <= CTX_RUNNING;
                end
                if (done_ok && (CTX_W'(i) == run_q)) begin
                    ctx_state_q[i] <= CTX_FREE;
                end
            end
        end
    end

    // Acquire lock, ring pointers and job counter
    always_ff @(posedge clk_i) begin
        if (clear) begin
            ptr_q     <= '0;
            run_q     <= '0;
            acq_ctx_q <= '0;
            lock_q    <= 1'b0;
            job_cnt_q <= '0;
        end else begin
            if (acq_grant) begin
                acq_ctx_q <= ptr_q;
                ptr_q     <= ptr_q + CTX_W'(1);
                job_cnt_q <= job_cnt_q + ID_WIDTH'(1);
                lock_q    <= 1'b1;
            end else if (trig_ok) begin
                lock_q    <= 1'b0;
            end
            if (done_ok) begin
                run_q <= run_q + CTX_W'(1);
            end
        end
    end

    // Queue occupancy: trigger adds a job, launch removes one (never both in a cycle with net change lost)
    always_ff @(posedge clk_i) begin
        if (clear) begin
            queued_q <= '0;
        end else begin
            case ({trig_ok, eng_launch})
                2'b10:   queued_q <= queued_q + CNT_W'(1);
                2'b01:   queued_q <= queued_q - CNT_W'(1);
                default: queued_q <= queued_q;
            endcase
        end
    end

    // Engine FSM
    always_ff @(posedge clk_i) begin
        if (clear) begin
            eng_q <= ENG_IDLE;
        end else begin
            case (eng_q)
                ENG_IDLE:  if (queued_q != '0) eng_q <= ENG_START;
                ENG_START: eng_q <= ENG_BUSY;
                ENG_BUSY:  if (done_i) eng_q <= ENG_IDLE;
                default:   eng_q <= ENG_IDLE;
            endcase
        end
    end

    // Completion event, statistics and sticky protocol error
    always_ff @(posedge clk_i) begin
        if (clear) begin
            evt_q      <= '0;
            finished_q <= '0;
            err_q      <= 1'b0;
        end else begin
            evt_q <= '0;
            if (done_ok) begin
                evt_q      <= N_CORES'(1) << ctx_owner_q[run_q];
                finished_q <= finished_q + FIN_W'(1);
            end
            if (trig_err || done_err) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hwpe_ctrl_ctx_sched.sv
// Directed self-checking bench for hwpe_ctrl_ctx_sched (default parameters).
module tb_hwpe_ctrl_ctx_sched;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        softclear_i = 1'b0;
    logic        acquire_i = 1'b0;
    logic [3:0]  acquire_core_i = '0;
    logic        acquire_ok_o;
    logic [7:0]  acquire_id_o;
    logic        trigger_i = 1'b0;
    logic        start_o;
    logic [1:0]  running_ctx_o;
    logic [1:0]  pointer_ctx_o;
    logic        done_i = 1'b0;
    logic [15:0] evt_o;
    logic        busy_o;
    logic [2:0]  queued_o;
    logic [15:0] finished_o;
    logic        err_o;

    int n_cmp = 0;
    int n_err = 0;

    hwpe_ctrl_ctx_sched #(
        .N_CONTEXT (4),
        .N_CORES   (16),
        .ID_WIDTH  (8)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .softclear_i    (softclear_i),
        .acquire_i      (acquire_i),
        .acquire_core_i (acquire_core_i),
        .acquire_ok_o   (acquire_ok_o),
        .acquire_id_o   (acquire_id_o),
        .trigger_i      (trigger_i),
        .start_o        (start_o),
        .running_ctx_o  (running_ctx_o),
        .pointer_ctx_o  (pointer_ctx_o),
        .done_i         (done_i),
        .evt_o          (evt_o),
        .busy_o         (busy_o),
        .queued_o       (queued_o),
        .finished_o     (finished_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // Pulse done while BUSY; check the completion cycle and the following one
    task automatic do_done(input string tag, input logic [15:0] exp_evt, input logic [15:0] exp_fin,
                           input logic [1:0] exp_run, input logic exp_start);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        check({tag, " evt"},      32'(evt_o),         32'(exp_evt));
        check({tag, " finished"}, 32'(finished_o),    32'(exp_fin));
        check({tag, " run"},      32'(running_ctx_o), 32'(exp_run));
        check({tag, " start+1"},  32'(start_o),       32'h0);
        check({tag, " busy+1"},   32'(busy_o),        32'h0);
        tick();
        check({tag, " start+2"},  32'(start_o),       32'(exp_start));
        check({tag, " evt+2"},    32'(evt_o),         32'h0);
        if (exp_start) begin
            check({tag, " run+2"}, 32'(running_ctx_o), 32'(exp_run));
            tick();
            check({tag, " busy+3"}, 32'(busy_o), 32'h1);
        end
    endtask

    initial begin
        // Basic job: reset, acquire, trigger latency, completion event
        do_reset();
        check("rst busy",     32'(busy_o),        32'h0);
        check("rst queued",   32'(queued_o),      32'h0);
        check("rst finished", 32'(finished_o),    32'h0);
        check("rst err",      32'(err_o),         32'h0);
        check("rst evt",      32'(evt_o),         32'h0);
        check("rst ptr",      32'(pointer_ctx_o), 32'h0);
        check("rst run",      32'(running_ctx_o), 32'h0);
        check("rst start",    32'(start_o),       32'h0);

        acquire_i = 1'b1;
        acquire_core_i = 4'd3;
        #1;
        check("a acq ok", 32'(acquire_ok_o), 32'h1);
        check("a acq id", 32'(acquire_id_o), 32'h0);
        tick();
        acquire_i = 1'b0;
        check("a ptr", 32'(pointer_ctx_o), 32'h1);
        trigger_i = 1'b1;
        tick();
        trigger_i = 1'b0;
        check("a start t+1",  32'(start_o),  32'h0);
        check("a queued t+1", 32'(queued_o), 32'h1);
        tick();
        check("a start t+2",  32'(start_o),       32'h1);
        check("a run t+2",    32'(running_ctx_o), 32'h0);
        check("a queued t+2", 32'(queued_o),      32'h0);
        tick();
        check("a start t+3",  32'(start_o), 32'h0);
        check("a busy t+3",   32'(busy_o),  32'h1);
        do_done("a done", 16'h0008, 16'd1, 2'd1, 1'b0);
        check("a err", 32'(err_o), 32'h0);

        // Fill the ring with the engine held busy on the first job
        do_reset();
        for (int k = 0; k < 4; k++) begin
            acquire_i = 1'b1;
            acquire_core_i = 4'(4 + k);
            #1;
            check($sformatf("fill%0d ok", k), 32'(acquire_ok_o), 32'h1);
            check($sformatf("fill%0d id", k), 32'(acquire_id_o), 32'(k));
            tick();
            acquire_i = 1'b0;
            trigger_i = 1'b1;
            tick();
            trigger_i = 1'b0;
        end
        check("full queued", 32'(queued_o),      32'h3);
        check("full busy",   32'(busy_o),        32'h1);
        check("full ptr",    32'(pointer_ctx_o), 32'h0);
        acquire_i = 1'b1;
        acquire_core_i = 4'd9;
        #1;
        check("full acq ok", 32'(acquire_ok_o), 32'h0);
        check("full acq id", 32'(acquire_id_o), 32'hFF);
        tick();

        // Acquire and done together on a full ring: denied, then granted on retry
        done_i = 1'b1;
        #1;
        check("acqdone ok", 32'(acquire_ok_o), 32'h0);
        check("acqdone id", 32'(acquire_id_o), 32'hFF);
        tick();
        done_i = 1'b0;
        check("acqdone evt",      32'(evt_o),         32'h0010);
        check("acqdone finished", 32'(finished_o),    32'd1);
        check("acqdone run",      32'(running_ctx_o), 32'h1);
        check("acqdone err",      32'(err_o),         32'h0);
        #1;
        check("retry ok", 32'(acquire_ok_o), 32'h1);
        check("retry id", 32'(acquire_id_o), 32'h4);
        tick();
        acquire_i = 1'b0;
        check("retry start", 32'(start_o),       32'h1);
        check("retry run",   32'(running_ctx_o), 32'h1);
        check("retry queued", 32'(queued_o),     32'h2);
        tick();
        trigger_i = 1'b1;
        tick();
        trigger_i = 1'b0;
        check("requeue queued", 32'(queued_o), 32'h3);

        // Back-to-back completions, running context wraps 3 -> 0
        do_done("b2b ctx1", 16'h0020, 16'd2, 2'd2, 1'b1);
        do_done("b2b ctx2", 16'h0040, 16'd3, 2'd3, 1'b1);
        do_done("b2b ctx3", 16'h0080, 16'd4, 2'd0, 1'b1);
        do_done("b2b ctx0", 16'h0200, 16'd5, 2'd1, 1'b0);
        check("b2b queued", 32'(queued_o), 32'h0);
        check("b2b err",    32'(err_o),    32'h0);

        // Trigger without acquire: error, no launch
        do_reset();
        trigger_i = 1'b1;
        tick();
        trigger_i = 1'b0;
        check("badtrig err", 32'(err_o), 32'h1);
        tick();
        check("badtrig start", 32'(start_o),  32'h0);
        check("badtrig busy",  32'(busy_o),   32'h0);
        check("badtrig queued", 32'(queued_o), 32'h0);

        // Second acquire while the lock is held is denied without error
        do_reset();
        acquire_i = 1'b1;
        acquire_core_i = 4'd1;
        #1;
        check("dbl first ok", 32'(acquire_ok_o), 32'h1);
        tick();
        #1;
        check("dbl second ok", 32'(acquire_ok_o), 32'h0);
        check("dbl second id", 32'(acquire_id_o), 32'hFF);
        tick();
        acquire_i = 1'b0;
        check("dbl ptr", 32'(pointer_ctx_o), 32'h1);
        check("dbl err", 32'(err_o),         32'h0);

        // Acquire+trigger together: trigger commits held context, acquire denied
        trigger_i = 1'b1;
        acquire_i = 1'b1;
        #1;
        check("acqtrig ok", 32'(acquire_ok_o), 32'h0);
        tick();
        trigger_i = 1'b0;
        acquire_i = 1'b0;
        check("acqtrig queued", 32'(queued_o), 32'h1);
        check("acqtrig err",    32'(err_o),    32'h0);

        // Softclear while busy, then a stray done
        do_reset();
        acquire_i = 1'b1;
        acquire_core_i = 4'd2;
        tick();
        acquire_i = 1'b0;
        trigger_i = 1'b1;
        tick();
        trigger_i = 1'b0;
        tick();
        tick();
        check("sc pre busy", 32'(busy_o), 32'h1);
        softclear_i = 1'b1;
        acquire_i = 1'b1;
        #1;
        check("sc acq ok", 32'(acquire_ok_o), 32'h0);
        tick();
        softclear_i = 1'b0;
        acquire_i = 1'b0;
        check("sc busy",     32'(busy_o),        32'h0);
        check("sc start",    32'(start_o),       32'h0);
        check("sc queued",   32'(queued_o),      32'h0);
        check("sc finished", 32'(finished_o),    32'h0);
        check("sc ptr",      32'(pointer_ctx_o), 32'h0);
        check("sc run",      32'(running_ctx_o), 32'h0);
        check("sc err",      32'(err_o),         32'h0);
        check("sc evt",      32'(evt_o),         32'h0);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        check("sc done err",      32'(err_o),      32'h1);
        check("sc done evt",      32'(evt_o),      32'h0);
        check("sc done finished", 32'(finished_o), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
